// File: rtl/io_bank.sv
// Board I/O peripheral: synchronised/debounced keys and toggles, sticky key-press
// events, indexed LED and seven-segment writes, and an indexed input read port.
module io_bank #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned NUM_TOGGLES     = 10,
  parameter int unsigned NUM_GREEN       = 8,
  parameter int unsigned NUM_HEX         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     LightLED,
  input  logic                     LightSevenSegment,
  input  logic                     ReadSwitch,
  input  logic [NUM_KEYS-1:0]      Keys,
  input  logic [NUM_TOGGLES-1:0]   Toggles,
  input  logic [31:0]              reg_a,
  input  logic [31:0]              reg_b,
  output logic [NUM_GREEN-1:0]     Green,
  output logic [NUM_TOGGLES-1:0]   Red,
  output logic [7*NUM_HEX-1:0]     Hex,
  output logic                     Switch,
  output logic                     SwitchValid
);

  localparam int unsigned NUM_IN = NUM_KEYS + NUM_TOGGLES;
  localparam int unsigned CW     = $clog2(DEBOUNCE_CYCLES);
  // Toggles occupy the low bits, keys the high bits; keys idle high (released).
  localparam logic [NUM_IN-1:0] IN_RST = {{NUM_KEYS{1'b1}}, {NUM_TOGGLES{1'b0}}};

  logic [NUM_IN-1:0]    w_raw;
  logic [NUM_IN-1:0]    r_sync1;
  logic [NUM_IN-1:0]    r_sync2;
  logic [NUM_IN-1:0]    r_stable;
  logic [CW-1:0]        r_cnt [NUM_IN];
  logic [NUM_IN-1:0]    w_accept;
  logic [NUM_KEYS-1:0]  w_press;
  logic [NUM_KEYS-1:0]  r_event;
  logic [NUM_KEYS-1:0]  w_rd_clr;
  logic                 w_rd_val;
  logic [7:0]           w_idx;
  logic [2:0]           w_digit;
  logic [NUM_GREEN-1:0]   r_green;
  logic [NUM_TOGGLES-1:0] r_red;
  logic [7*NUM_HEX-1:0]   r_hex;
  logic                 r_switch;
  logic                 r_switch_valid;
  logic                 w_unused;

  assign w_raw    = {Keys, Toggles};
  assign w_idx    = reg_a[7:0];
  assign w_digit  = reg_a[2:0];
  assign w_unused = ^{reg_a[31:8], reg_b[31:5]};

  function automatic logic [6:0] f_hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // A bit is accepted on the cycle its counter has seen DEBOUNCE_CYCLES mismatches.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_accept[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  assign w_press = w_accept[NUM_IN-1:NUM_TOGGLES] & r_stable[NUM_IN-1:NUM_TOGGLES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1  <= IN_RST;
      r_sync2  <= IN_RST;
      r_stable <= IN_RST;
      for (int i = 0; i < NUM_IN; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_IN; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Read address decode; event reads also flag a clear.
  always_comb begin
    w_rd_val = 1'b0;
    w_rd_clr = '0;
    for (int t = 0; t < NUM_TOGGLES; t++) begin
      if (w_idx == 8'(t)) w_rd_val = r_stable[t];
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (w_idx == 8'(16 + k)) w_rd_val = ~r_stable[NUM_TOGGLES + k];
      if (w_idx == 8'(32 + k)) begin
        w_rd_val    = r_event[k];
        w_rd_clr[k] = 1'b1;
      end
    end
  end

  // A press edge in the same cycle as a read-and-clear keeps the event set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_event        <= '0;
      r_switch       <= 1'b0;
      r_switch_valid <= 1'b0;
    end else begin
      r_event        <= (r_event & ~(w_rd_clr & {NUM_KEYS{ReadSwitch}})) | w_press;
      r_switch_valid <= ReadSwitch;
      if (ReadSwitch) r_switch <= w_rd_val;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_green <= '0;
      r_red   <= '0;
      r_hex   <= '1;
    end else begin
      if (LightLED) begin
        for (int g = 0; g < NUM_GREEN; g++) begin
          if (w_idx == 8'(g)) r_green[g] <= reg_b[0];
        end
        for (int r = 0; r < NUM_TOGGLES; r++) begin
          if (w_idx == 8'(NUM_GREEN + r)) r_red[r] <= reg_b[0];
        end
      end
      if (LightSevenSegment) begin
        for (int h = 0; h < NUM_HEX; h++) begin
          if (w_digit == 3'(h)) r_hex[7*h +: 7] <= reg_b[4] ? 7'h7F : f_hex7(reg_b[3:0]);
        end
      end
    end
  end

  assign Green       = r_green;
  assign Red         = r_red;
  assign Hex         = r_hex;
  assign Switch      = r_switch;
  assign SwitchValid = r_switch_valid;

endmodule

// File: tb/tb_io_bank.sv
// Directed bench for io_bank with a short debounce window.
module tb_io_bank;

  localparam int unsigned NK = 4;
  localparam int unsigned NT = 10;
  localparam int unsigned NG = 8;
  localparam int unsigned NH = 4;
  localparam int unsigned DB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          LightLED;
  logic          LightSevenSegment;
  logic          ReadSwitch;
  logic [NK-1:0] Keys;
  logic [NT-1:0] Toggles;
  logic [31:0]   reg_a;
  logic [31:0]   reg_b;
  logic [NG-1:0] Green;
  logic [NT-1:0] Red;
  logic [7*NH-1:0] Hex;
  logic          Switch;
  logic          SwitchValid;

  int checks = 0;
  int errors = 0;
  logic [27:0] hx;

  io_bank #(
    .NUM_KEYS(NK), .NUM_TOGGLES(NT), .NUM_GREEN(NG), .NUM_HEX(NH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clock(clock), .reset(reset), .LightLED(LightLED), .LightSevenSegment(LightSevenSegment),
    .ReadSwitch(ReadSwitch), .Keys(Keys), .Toggles(Toggles), .reg_a(reg_a), .reg_b(reg_b),
    .Green(Green), .Red(Red), .Hex(Hex), .Switch(Switch), .SwitchValid(SwitchValid)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] idx, input logic exp, input string tag);
    ReadSwitch = 1'b1;
    reg_a      = {24'h0, idx};
    tick(1);
    ReadSwitch = 1'b0;
    chk({tag, ".val"}, 32'(Switch), 32'(exp));
    chk({tag, ".vld"}, 32'(SwitchValid), 32'd1);
    tick(1);
    chk({tag, ".vld_drop"}, 32'(SwitchValid), 32'd0);
    chk({tag, ".hold"}, 32'(Switch), 32'(exp));
  endtask

  task automatic wr_led(input logic [7:0] idx, input logic v);
    LightLED = 1'b1;
    reg_a    = {24'h0, idx};
    reg_b    = {31'h0, v};
    tick(1);
    LightLED = 1'b0;
  endtask

  task automatic wr_hex(input logic [7:0] idx, input logic [4:0] v);
    LightSevenSegment = 1'b1;
    reg_a             = {24'h0, idx};
    reg_b             = {27'h0, v};
    tick(1);
    LightSevenSegment = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".green"}, 32'(Green), 32'h0);
    chk({tag, ".red"}, 32'(Red), 32'h0);
    chk({tag, ".hex"}, 32'(Hex), 32'h0FFFFFFF);
    chk({tag, ".sw"}, 32'(Switch), 32'h0);
    chk({tag, ".swv"}, 32'(SwitchValid), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    LightLED = 1'b0;
    LightSevenSegment = 1'b0;
    ReadSwitch = 1'b0;
    Keys = '1;
    Toggles = '0;
    reg_a = '0;
    reg_b = '0;
    tick(3);
    chk_reset_outputs("reset");
    reset = 1'b1;
    tick(8);
    chk_reset_outputs("post_reset");

    // Stable toggle, and out-of-range / unused indices.
    Toggles[3] = 1'b1;
    tick(10);
    rd(8'd3, 1'b1, "tog3");
    rd(8'd4, 1'b0, "tog4");
    rd(8'd12, 1'b0, "gap_idx12");

    // Glitches of 2 and 3 cycles are shorter than the window.
    Toggles[5] = 1'b1;
    tick(2);
    Toggles[5] = 1'b0;
    tick(10);
    rd(8'd5, 1'b0, "glitch2");
    Toggles[7] = 1'b1;
    tick(3);
    Toggles[7] = 1'b0;
    tick(10);
    rd(8'd7, 1'b0, "glitch3");

    // Key press event is sticky until read, level readable while held.
    Keys[1] = 1'b0;
    tick(10);
    rd(8'd33, 1'b1, "ev1_first");
    rd(8'd33, 1'b0, "ev1_second");
    rd(8'd17, 1'b1, "key1_level");
    rd(8'd16, 1'b0, "key0_level");
    rd(8'd40, 1'b0, "bad_idx40");

    // New press edge coincides with a read of an already-set event.
    Keys[2] = 1'b0;
    tick(10);
    Keys[2] = 1'b1;
    tick(10);
    rd(8'd18, 1'b0, "key2_released");
    Keys[2] = 1'b0;
    tick(5);
    ReadSwitch = 1'b1;
    reg_a = 32'd34;
    tick(1);
    ReadSwitch = 1'b0;
    chk("ev2_coincide.val", 32'(Switch), 32'd1);
    chk("ev2_coincide.vld", 32'(SwitchValid), 32'd1);
    tick(1);
    rd(8'd34, 1'b1, "ev2_kept");
    rd(8'd34, 1'b0, "ev2_cleared");

    // LED writes.
    wr_led(8'd9, 1'b1);
    chk("led_red1", 32'(Red), 32'h002);
    chk("led_green_untouched", 32'(Green), 32'h00);
    wr_led(8'd200, 1'b1);
    chk("led200_red", 32'(Red), 32'h002);
    chk("led200_green", 32'(Green), 32'h00);
    wr_led(8'd0, 1'b1);
    chk("led_green0", 32'(Green), 32'h01);
    wr_led(8'd17, 1'b1);
    chk("led_red9", 32'(Red), 32'h202);
    wr_led(8'd18, 1'b1);
    chk("led18_ignored", 32'(Red), 32'h202);
    wr_led(8'd9, 1'b0);
    chk("led_red1_clear", 32'(Red), 32'h200);

    // Seven-segment writes.
    hx = 28'hFFFFFFF;
    wr_hex(8'd2, 5'h0A);
    hx[20:14] = 7'b0001000;
    chk("hex2_A", 32'(Hex), 32'(hx));
    wr_hex(8'd2, 5'h10);
    hx[20:14] = 7'b1111111;
    chk("hex2_blank", 32'(Hex), 32'(hx));
    wr_hex(8'd5, 5'h00);
    chk("hex5_ignored", 32'(Hex), 32'(hx));
    wr_hex(8'd0, 5'h05);
    hx[6:0] = 7'b0010010;
    chk("hex0_5", 32'(Hex), 32'(hx));
    wr_hex(8'd3, 5'h0E);
    hx[27:21] = 7'b0000110;
    chk("hex3_E", 32'(Hex), 32'(hx));

    // All three strobes in one cycle share reg_a=1, reg_b=3.
    LightLED = 1'b1;
    LightSevenSegment = 1'b1;
    ReadSwitch = 1'b1;
    reg_a = 32'd1;
    reg_b = 32'h03;
    tick(1);
    LightLED = 1'b0;
    LightSevenSegment = 1'b0;
    ReadSwitch = 1'b0;
    hx[13:7] = 7'b0110000;
    chk("simul_green", 32'(Green), 32'h03);
    chk("simul_hex", 32'(Hex), 32'(hx));
    chk("simul_sw", 32'(Switch), 32'd0);
    chk("simul_swv", 32'(SwitchValid), 32'd1);
    tick(1);

    // Reset during an in-flight read: no valid pulse, everything cleared.
    rd(8'd3, 1'b1, "pre_reset_read");
    ReadSwitch = 1'b1;
    reg_a = 32'd3;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    tick(1);
    ReadSwitch = 1'b0;
    chk("async_reset.no_valid", 32'(SwitchValid), 32'd0);
    reset = 1'b1;
    Toggles = '0;
    Keys = '1;
    tick(8);
    rd(8'd33, 1'b0, "ev1_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
